// File: rtl/hdmi_display_sequencer.sv
// hdmi_display_sequencer
//   Power-up/power-down sequencer for the HDMI output path. It turns the
//   level display request from the HDMI register into an ordered bring-up:
//   wait for pixel PLL lock, hold the TMDS encoders in reset, start the
//   timing generator, then open video on a frame boundary. On disable it
//   drains to the end of the current frame before shutting down.
//
// Ports
//   HCLK_i         system clock, rising edge
//   HRESET_i       synchronous reset, active-high
//   display_on_i   display request level
//   pll_lock_i     pixel PLL lock, already synchronised to HCLK
//   frame_start_i  one-cycle pulse at each frame start from the timing generator
//   tmds_rst_o     TMDS encoder reset, active-high
//   tg_enable_o    timing generator run enable
//   video_en_o     gates active pixel data onto the TMDS encoders
//   seq_err_o      sticky lock-timeout / lock-loss flag
//   seq_state_o    current state encoding for status readback
module hdmi_display_sequencer #(
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic       HCLK_i,
  input  logic       HRESET_i,
  input  logic       display_on_i,
  input  logic       pll_lock_i,
  input  logic       frame_start_i,
  output logic       tmds_rst_o,
  output logic       tg_enable_o,
  output logic       video_en_o,
  output logic       seq_err_o,
  output logic [2:0] seq_state_o
);

  localparam logic [2:0] OFF       = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] RST_HOLD  = 3'd2;
  localparam logic [2:0] TG_START  = 3'd3;
  localparam logic [2:0] ON        = 3'd4;
  localparam logic [2:0] DRAIN     = 3'd5;
  localparam logic [2:0] ERROR     = 3'd6;

  localparam int TW = $clog2(LOCK_TIMEOUT);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int FW = $clog2(SETTLE_FRAMES + 1);

  localparam logic [TW-1:0] TimerLast = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RstLast   = RW'(RST_CYCLES - 1);
  localparam logic [FW-1:0] FrameLast = FW'(SETTLE_FRAMES - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          err_q, err_d;
  logic          tmds_rst_q, tmds_rst_d;
  logic          tg_en_q, tg_en_d;
  logic          video_en_q, video_en_d;

  // Next-state selection. Within each state the checks are ordered by
  // priority: lock loss (ON/DRAIN) first, then a dropped request, then the
  // state's own progress condition. In DRAIN a re-raised request in the
  // same cycle as frame_start cancels the shutdown, so video never blinks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF: begin
        if (display_on_i) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!display_on_i)          state_d = OFF;
        else if (pll_lock_i)        state_d = RST_HOLD;
        else if (timer_q == TimerLast) state_d = ERROR;
      end
      RST_HOLD: begin
        if (!display_on_i)          state_d = OFF;
        else if (!pll_lock_i)       state_d = WAIT_LOCK;
        else if (rst_cnt_q == RstLast) state_d = TG_START;
      end
      TG_START: begin
        if (!display_on_i)          state_d = OFF;
        else if (frame_start_i && (frame_cnt_q == FrameLast)) state_d = ON;
      end
      ON: begin
        if (!pll_lock_i)            state_d = ERROR;
        else if (!display_on_i)     state_d = DRAIN;
      end
      DRAIN: begin
        if (!pll_lock_i)            state_d = ERROR;
        else if (display_on_i)      state_d = ON;
        else if (frame_start_i)     state_d = OFF;
      end
      ERROR: begin
        if (!display_on_i)          state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

  // Counters restart from zero whenever the state changes, so every entry
  // into a state (including re-entry after a lock glitch) starts a fresh
  // count. The lock timer saturates instead of wrapping.
  always_comb begin
    timer_d     = '0;
    rst_cnt_d   = '0;
    frame_cnt_d = '0;
    if (state_d == state_q) begin
      timer_d     = timer_q;
      rst_cnt_d   = rst_cnt_q;
      frame_cnt_d = frame_cnt_q;
      if ((state_q == WAIT_LOCK) && (timer_q != TimerLast))
        timer_d = timer_q + TW'(1);
      if ((state_q == RST_HOLD) && (rst_cnt_q != RstLast))
        rst_cnt_d = rst_cnt_q + RW'(1);
      if ((state_q == TG_START) && frame_start_i && (frame_cnt_q != FrameLast))
        frame_cnt_d = frame_cnt_q + FW'(1);
    end
  end

  // The error flag is set on any entry into ERROR and only cleared by a
  // fresh request leaving OFF, so software can read it after shutdown.
  // Output enables are decoded from the next state so that the registered
  // outputs always line up with seq_state_o.
  always_comb begin
    err_d = err_q;
    if (state_d == ERROR)
      err_d = 1'b1;
    else if ((state_q == OFF) && (state_d == WAIT_LOCK))
      err_d = 1'b0;
    tmds_rst_d = (state_d == OFF) || (state_d == WAIT_LOCK) ||
                 (state_d == RST_HOLD) || (state_d == ERROR) || (state_d == 3'd7);
    tg_en_d    = (state_d == TG_START) || (state_d == ON) || (state_d == DRAIN);
    video_en_d = (state_d == ON) || (state_d == DRAIN);
  end

  always_ff @(posedge HCLK_i) begin
    if (HRESET_i) begin
      state_q     <= OFF;
      timer_q     <= '0;
      rst_cnt_q   <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      tmds_rst_q  <= 1'b1;
      tg_en_q     <= 1'b0;
      video_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rst_cnt_q   <= rst_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      tmds_rst_q  <= tmds_rst_d;
      tg_en_q     <= tg_en_d;
      video_en_q  <= video_en_d;
    end
  end

  assign tmds_rst_o  = tmds_rst_q;
  assign tg_enable_o = tg_en_q;
  assign video_en_o  = video_en_q;
  assign seq_err_o   = err_q;
  assign seq_state_o = state_q;

endmodule

// File: tb/tb_hdmi_display_sequencer.sv
// tb_hdmi_display_sequencer
//   Self-checking bench for hdmi_display_sequencer. Directed scenarios with
//   hand-counted expectations, followed by a long randomized run. Every cycle
//   the DUT outputs are compared with a behavioural model that tracks the
//   sequencer phase, time spent in it and frames seen.
module tb_hdmi_display_sequencer;

  localparam int LT = 100;
  localparam int RC = 16;
  localparam int SF = 2;

  logic       HCLK;
  logic       HRESET;
  logic       displayOn;
  logic       pllLock;
  logic       frameStart;
  logic       tmdsRst;
  logic       tgEnable;
  logic       videoEn;
  logic       seqErr;
  logic [2:0] seqState;

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase number, cycles spent in phase, frames counted.
  int mPhase = 0;
  int mTime  = 0;
  int mFrames = 0;
  int mErr   = 0;

  hdmi_display_sequencer #(
    .LOCK_TIMEOUT (LT),
    .RST_CYCLES   (RC),
    .SETTLE_FRAMES(SF)
  ) dut (
    .HCLK_i       (HCLK),
    .HRESET_i     (HRESET),
    .display_on_i (displayOn),
    .pll_lock_i   (pllLock),
    .frame_start_i(frameStart),
    .tmds_rst_o   (tmdsRst),
    .tg_enable_o  (tgEnable),
    .video_en_o   (videoEn),
    .seq_err_o    (seqErr),
    .seq_state_o  (seqState)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the rules of the sequencer:
  // phase 0 off, 1 waiting for lock, 2 encoder reset hold, 3 timing start,
  // 4 on, 5 draining, 6 error.
  task automatic modelStep(input bit rst, input bit on, input bit lock, input bit fs);
    int nxt;
    if (rst) begin
      mPhase = 0; mTime = 0; mFrames = 0; mErr = 0;
      return;
    end
    nxt = mPhase;
    if (mPhase == 0 && on) begin
      nxt = 1;
      mErr = 0;
    end else if (mPhase == 1) begin
      if (!on) nxt = 0;
      else if (lock) nxt = 2;
      else if (mTime + 1 >= LT) nxt = 6;
    end else if (mPhase == 2) begin
      if (!on) nxt = 0;
      else if (!lock) nxt = 1;
      else if (mTime + 1 >= RC) nxt = 3;
    end else if (mPhase == 3) begin
      if (!on) nxt = 0;
      else if (fs && mFrames + 1 >= SF) nxt = 4;
      else if (fs) mFrames++;
    end else if (mPhase == 4) begin
      if (!lock) nxt = 6;
      else if (!on) nxt = 5;
    end else if (mPhase == 5) begin
      if (!lock) nxt = 6;
      else if (on) nxt = 4;
      else if (fs) nxt = 0;
    end else if (mPhase == 6) begin
      if (!on) nxt = 0;
    end
    if (nxt == 6) mErr = 1;
    if (nxt != mPhase) begin
      mPhase = nxt; mTime = 0; mFrames = 0;
    end else begin
      mTime++;
    end
  endtask

  task automatic checkOutput();
    bit expRst, expTg, expVid;
    expRst = (mPhase <= 2) || (mPhase == 6);
    expTg  = (mPhase >= 3) && (mPhase <= 5);
    expVid = (mPhase == 4) || (mPhase == 5);
    checkVal("model seq_state", int'(seqState), mPhase);
    checkVal("model tmds_rst", int'(tmdsRst), int'(expRst));
    checkVal("model tg_enable", int'(tgEnable), int'(expTg));
    checkVal("model video_en", int'(videoEn), int'(expVid));
    checkVal("model seq_err", int'(seqErr), mErr);
  endtask

  // Drive inputs away from the active edge, let the DUT and the model both
  // take the edge, then compare shortly after it.
  task automatic applyStimulus(input bit rst, input bit on, input bit lock, input bit fs);
    @(negedge HCLK);
    HRESET = rst; displayOn = on; pllLock = lock; frameStart = fs;
    @(posedge HCLK);
    modelStep(rst, on, lock, fs);
    #1;
    checkOutput();
  endtask

  task automatic bringUp();
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 200 && seqState != 3'd4; i++)
      applyStimulus(0, 1, 1, (i % 6) == 5);
    checkVal("bringUp reaches ON", int'(seqState), 4);
  endtask

  initial begin
    int n;
    bit rOn, rLock, rFs, rRst;
    int lowLeft;
    HRESET = 1'b1; displayOn = 1'b0; pllLock = 1'b0; frameStart = 1'b0;

    // Reset state
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkVal("reset tmds_rst", int'(tmdsRst), 1);
    checkVal("reset tg_enable", int'(tgEnable), 0);
    checkVal("reset video_en", int'(videoEn), 0);
    checkVal("reset seq_state", int'(seqState), 0);

    // Normal power-up: lock arrives at +5
    applyStimulus(0, 1, 0, 0);
    checkVal("up enters WAIT_LOCK", int'(seqState), 1);
    repeat (4) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkVal("up enters RST_HOLD", int'(seqState), 2);
    n = 0;
    while (tmdsRst && n < 100) begin
      applyStimulus(0, 1, 1, 0);
      n++;
    end
    checkVal("up reset hold length", n, RC);
    checkVal("up TG_START tg_enable", int'(tgEnable), 1);
    repeat (3) applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1);
    checkVal("up video after 1st frame", int'(videoEn), 0);
    repeat (4) applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1);
    checkVal("up video after 2nd frame", int'(videoEn), 1);
    checkVal("up seq_state ON", int'(seqState), 4);

    // Drain to frame end
    applyStimulus(0, 0, 1, 0);
    checkVal("drain video held", int'(videoEn), 1);
    repeat (3) applyStimulus(0, 0, 1, 0);
    checkVal("drain video still held", int'(videoEn), 1);
    applyStimulus(0, 0, 1, 1);
    checkVal("drain off video", int'(videoEn), 0);
    checkVal("drain off tg_enable", int'(tgEnable), 0);
    checkVal("drain off tmds_rst", int'(tmdsRst), 1);
    checkVal("drain off seq_state", int'(seqState), 0);

    // Cancel in DRAIN, then lock loss in ON
    bringUp();
    applyStimulus(0, 0, 1, 0);
    checkVal("cancel in DRAIN", int'(seqState), 5);
    applyStimulus(0, 0, 1, 0);
    checkVal("cancel video held", int'(videoEn), 1);
    applyStimulus(0, 1, 1, 0);
    checkVal("cancel back ON", int'(seqState), 4);
    checkVal("cancel video never drops", int'(videoEn), 1);
    applyStimulus(0, 1, 0, 0);
    checkVal("loss to ERROR", int'(seqState), 6);
    checkVal("loss video off", int'(videoEn), 0);
    checkVal("loss seq_err", int'(seqErr), 1);
    applyStimulus(0, 0, 1, 0);
    checkVal("loss exits to OFF", int'(seqState), 0);
    checkVal("loss err sticky in OFF", int'(seqErr), 1);

    // Lock timeout
    applyStimulus(0, 1, 0, 0);
    checkVal("timeout err cleared on request", int'(seqErr), 0);
    n = 0;
    while (seqState != 3'd6 && n < 300) begin
      applyStimulus(0, 1, 0, 0);
      n++;
    end
    checkVal("timeout cycles in WAIT_LOCK", n, LT);
    checkVal("timeout seq_err", int'(seqErr), 1);
    applyStimulus(0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkVal("timeout err sticky", int'(seqErr), 1);

    // Lock glitch during reset hold
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    checkVal("glitch in RST_HOLD", int'(seqState), 2);
    repeat (7) applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkVal("glitch back to WAIT_LOCK", int'(seqState), 1);
    applyStimulus(0, 1, 1, 0);
    n = 0;
    while (tmdsRst && n < 100) begin
      applyStimulus(0, 1, 1, 0);
      n++;
    end
    checkVal("glitch full hold repeated", n, RC);

    // Reset while ON
    bringUp();
    applyStimulus(1, 1, 1, 0);
    checkVal("midreset tmds_rst", int'(tmdsRst), 1);
    checkVal("midreset tg_enable", int'(tgEnable), 0);
    checkVal("midreset video_en", int'(videoEn), 0);
    checkVal("midreset seq_err", int'(seqErr), 0);
    checkVal("midreset seq_state", int'(seqState), 0);

    // Randomized run against the model
    rOn = 1'b0; rLock = 1'b1; lowLeft = 0;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom % 150 == 0) rOn = !rOn;
      if (lowLeft > 0) begin
        rLock = 1'b0;
        lowLeft--;
      end else begin
        rLock = 1'b1;
        if ($urandom % 80 == 0)
          lowLeft = ($urandom % 2) ? int'($urandom_range(1, 4)) : int'($urandom_range(90, 130));
      end
      rFs  = ($urandom % 10) == 0;
      rRst = ($urandom % 700) == 0;
      applyStimulus(rRst, rOn, rLock, rFs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
